// File: rtl/cache_bus_mem_responder.sv
// Memory-side responder for the cache burst bus: word-organised RAM with
// independent read and write burst FSMs and configurable access latency.
module cache_bus_mem_responder #(
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        ren_i,
  input  logic        rready_i,
  input  logic [31:0] raddr_i,
  input  logic [3:0]  rlen_i,
  input  logic [3:0]  rsel_i,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  input  logic        wen_i,
  input  logic        wvalid_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wsel_i,
  input  logic        wlast_i,
  input  logic [3:0]  wlen_i,
  output logic        wdata_resp_o,
  output logic        proto_err_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned RCW   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int unsigned WCW   = (WR_LATENCY > 1) ? $clog2(WR_LATENCY) : 1;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST, R_WAIT_LOW} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP, W_WAIT_LOW} wstate_t;

  logic [31:0]       r_mem [0:DEPTH-1];

  rstate_t           r_rstate;
  logic [ADDR_W-1:0] r_rbase;
  logic [3:0]        r_rlen;
  logic [3:0]        r_rk;
  logic [RCW-1:0]    r_rcnt;
  logic [31:0]       r_rdata;
  logic              r_rvalid;

  wstate_t           r_wstate;
  logic [3:0]        r_wlen;
  logic [3:0]        r_wk;
  logic [WCW-1:0]    r_wcnt;
  logic              r_wresp;
  logic              r_perr;

  logic [ADDR_W-1:0] w_raddr_idx;
  logic [ADDR_W-1:0] w_rnext_idx;
  logic [ADDR_W-1:0] w_waddr_idx;
  logic              w_we;
  logic              w_unused;

  assign w_raddr_idx = raddr_i[ADDR_W+1:2];
  assign w_rnext_idx = r_rbase + ADDR_W'(r_rk) + ADDR_W'(1);
  assign w_waddr_idx = waddr_i[ADDR_W+1:2];
  assign w_we        = (r_wstate == W_RESP);
  assign w_unused    = ^{rsel_i, raddr_i[31:ADDR_W+2], raddr_i[1:0],
                         waddr_i[31:ADDR_W+2], waddr_i[1:0]};

  // Write port: address/data come from the live bus during each response pulse
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wsel_i[b]) r_mem[w_waddr_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read FSM: the data register samples memory before same-edge writes land
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rbase  <= '0;
      r_rlen   <= '0;
      r_rk     <= '0;
      r_rcnt   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (ce_i && ren_i) begin
            r_rbase <= w_raddr_idx;
            r_rlen  <= rlen_i;
            r_rk    <= '0;
            if (RD_LATENCY == 1) begin
              r_rdata  <= r_mem[w_raddr_idx];
              r_rvalid <= 1'b1;
              r_rstate <= R_BURST;
            end else begin
              r_rcnt   <= RCW'(RD_LATENCY - 1);
              r_rstate <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_rcnt == RCW'(1)) begin
            r_rdata  <= r_mem[r_rbase];
            r_rvalid <= 1'b1;
            r_rstate <= R_BURST;
          end else begin
            r_rcnt <= r_rcnt - RCW'(1);
          end
        end
        R_BURST: begin
          if (rready_i) begin
            if (r_rk == r_rlen) begin
              r_rvalid <= 1'b0;
              r_rstate <= R_WAIT_LOW;
            end else begin
              r_rk    <= r_rk + 4'd1;
              r_rdata <= r_mem[w_rnext_idx];
            end
          end
        end
        R_WAIT_LOW: begin
          if (!ren_i) r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_wlen   <= '0;
      r_wk     <= '0;
      r_wcnt   <= '0;
      r_wresp  <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (ce_i && wen_i && wvalid_i) begin
            r_wlen <= wlen_i;
            r_wk   <= '0;
            if (WR_LATENCY == 1) begin
              r_wresp  <= 1'b1;
              r_wstate <= W_RESP;
            end else begin
              r_wcnt   <= WCW'(WR_LATENCY - 1);
              r_wstate <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          if (r_wcnt == WCW'(1)) begin
            r_wresp  <= 1'b1;
            r_wstate <= W_RESP;
          end else begin
            r_wcnt <= r_wcnt - WCW'(1);
          end
        end
        W_RESP: begin
          if (!wvalid_i || (wlast_i != (r_wk == r_wlen))) r_perr <= 1'b1;
          if (r_wk == r_wlen) begin
            r_wresp  <= 1'b0;
            r_wstate <= W_WAIT_LOW;
          end else begin
            r_wk <= r_wk + 4'd1;
          end
        end
        W_WAIT_LOW: begin
          if (!wen_i) r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign rdata_o       = r_rdata;
  assign rdata_valid_o = r_rvalid;
  assign wdata_resp_o  = r_wresp;
  assign proto_err_o   = r_perr;

endmodule

// File: tb/tb_cache_bus_mem_responder.sv
// Randomized bench for cache_bus_mem_responder against a cycle-level
// reference built from the bus timing rules and a word-array memory model.
module tb_cache_bus_mem_responder;

  localparam int ADDR_W = 10;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk, rst, ce;
  logic        ren, rready, wen, wvalid, wlast;
  logic [31:0] raddr, waddr, wdata, rdata;
  logic [3:0]  rlen, rsel, wsel, wlen;
  logic        rvalid, wresp, perr;

  cache_bus_mem_responder #(
    .ADDR_W(ADDR_W), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
  ) dut (
    .clk(clk), .rst(rst), .ce_i(ce),
    .ren_i(ren), .rready_i(rready), .raddr_i(raddr), .rlen_i(rlen),
    .rsel_i(rsel), .rdata_o(rdata), .rdata_valid_o(rvalid),
    .wen_i(wen), .wvalid_i(wvalid), .waddr_i(waddr), .wdata_i(wdata),
    .wsel_i(wsel), .wlast_i(wlast), .wlen_i(wlen),
    .wdata_resp_o(wresp), .proto_err_o(perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem_m [0:DEPTH-1];
  logic [31:0] wd_beats [0:15];
  bit          err_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] a, input int k);
    logic [ADDR_W-1:0] b;
    b = a[ADDR_W+1:2];
    return (int'(b) + k) % DEPTH;
  endfunction

  // Runs an optional read burst and an optional write burst (accepted wdly
  // cycles later); cycle 0 is the read acceptance cycle.
  task automatic run(input bit rd_en, input logic [31:0] ra, input int rl,
                     input int stall_beat, input int stall_n,
                     input bit wr_en, input logic [31:0] wa, input int wl,
                     input logic [3:0] sel, input int err_beat, input int wdly);
    int          rbeat, stall_left, ncyc, cw, wb, rd_cyc, wr_cyc, idx;
    bit          rv_exp, resp_exp, adv, nv, commit;
    logic [31:0] rd_exp;
    rbeat = 0; stall_left = stall_n; rv_exp = 0; resp_exp = 0; rd_exp = '0;
    rd_cyc = rd_en ? RD_LAT + rl + stall_n + 2 : 0;
    wr_cyc = wr_en ? wdly + WR_LAT + wl + 2 : 0;
    ncyc = ((rd_cyc > wr_cyc) ? rd_cyc : wr_cyc) + 1;
    for (int c = 0; c < ncyc; c++) begin
      cw = c - wdly;
      check("rvalid", 32'(rvalid), 32'(rv_exp));
      if (rv_exp) check("rdata", rdata, rd_exp);
      check("wresp", 32'(wresp), 32'(resp_exp));
      check("perr", 32'(perr), 32'(err_exp));
      ren    = rd_en && (rbeat <= rl);
      raddr  = ra;
      rlen   = 4'(rl);
      rsel   = 4'($urandom);
      rready = 1'b1;
      if (rv_exp && rbeat == stall_beat && stall_left > 0) begin
        rready = 1'b0;
        stall_left--;
      end
      wb = (cw < WR_LAT) ? 0 : cw - WR_LAT;
      if (wb > wl) wb = wl;
      wen    = wr_en && cw >= 0 && cw <= WR_LAT + wl;
      wvalid = wen;
      waddr  = wa + 32'(4 * wb);
      wdata  = wd_beats[wb];
      wsel   = sel;
      wlast  = (wb == wl) || (wb == err_beat);
      wlen   = 4'(wl);
      // Read data is sampled from the model before this cycle's write lands
      if (rd_en) begin
        adv = rv_exp && rready;
        if (adv) rbeat++;
        nv = (c + 1 >= RD_LAT) && (rbeat <= rl);
        if (nv && (adv || !rv_exp)) rd_exp = mem_m[widx(ra, rbeat)];
        rv_exp = nv;
      end
      commit = wr_en && cw >= WR_LAT && cw <= WR_LAT + wl;
      if (commit) begin
        idx = widx(waddr, 0);
        for (int b = 0; b < 4; b++)
          if (sel[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
        if (wlast != (wb == wl)) err_exp = 1'b1;
      end
      resp_exp = wr_en && (cw + 1) >= WR_LAT && (cw + 1) <= WR_LAT + wl;
      tick();
    end
    ren = 0; wen = 0; wvalid = 0; wlast = 0;
  endtask

  initial begin
    bit          rd_en, wr_en;
    int          mode, rl, wl, eb, sb;
    logic [31:0] ra, wa;

    rst = 1; ce = 1; ren = 0; rready = 0; raddr = '0; rlen = '0; rsel = '0;
    wen = 0; wvalid = 0; waddr = '0; wdata = '0; wsel = '0; wlast = 0; wlen = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_wresp", 32'(wresp), 32'h0);
    check("rst_perr", 32'(perr), 32'h0);
    rst = 0;
    tick();

    for (int i = 0; i < DEPTH / 16; i++) begin
      for (int k = 0; k < 16; k++) wd_beats[k] = $urandom;
      run(0, '0, 0, -1, 0, 1, 32'(i * 64), 15, 4'hF, -1, 0);
    end

    for (int k = 0; k < 16; k++) wd_beats[k] = 32'h10000000 + 32'(k);
    run(0, '0, 0, -1, 0, 1, 32'h100, 7, 4'hF, -1, 0);
    run(1, 32'h100, 7, -1, 0, 0, '0, 0, 4'h0, -1, 0);

    wd_beats[0] = 32'hAAAABBBB;
    run(0, '0, 0, -1, 0, 1, 32'h104, 0, 4'b0011, -1, 0);
    run(1, 32'h104, 0, -1, 0, 0, '0, 0, 4'h0, -1, 0);

    wd_beats[0] = 32'hDEADBEEF;
    run(1, 32'h108, 0, -1, 0, 1, 32'h108, 0, 4'hF, -1, 0);
    run(1, 32'h108, 0, -1, 0, 0, '0, 0, 4'h0, -1, 0);

    run(1, 32'h100, 7, 3, 2, 0, '0, 0, 4'h0, -1, 0);

    for (int k = 0; k < 16; k++) wd_beats[k] = 32'h20000000 + 32'(k);
    run(0, '0, 0, -1, 0, 1, 32'h200, 7, 4'hF, 2, 0);

    // Chip enable low: held requests must not start a burst
    ce = 0; ren = 1; wen = 1; wvalid = 1; raddr = 32'h200; rlen = 4'd3; rready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ce_rvalid", 32'(rvalid), 32'h0);
      check("ce_wresp", 32'(wresp), 32'h0);
    end
    ren = 0; wen = 0; wvalid = 0; ce = 1;
    tick();

    // Asynchronous reset in the middle of a read burst
    ren = 1; raddr = 32'h200; rlen = 4'd7; rready = 1;
    repeat (4) tick();
    check("pre_rst_rvalid", 32'(rvalid), 32'h1);
    check("pre_rst_perr", 32'(perr), 32'h1);
    #3 rst = 1;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'h0);
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_wresp", 32'(wresp), 32'h0);
    check("mid_rst_perr", 32'(perr), 32'h0);
    ren = 0;
    err_exp = 1'b0;
    tick();
    rst = 0;
    tick();
    run(1, 32'h200, 7, -1, 0, 0, '0, 0, 4'h0, -1, 0);

    for (int t = 0; t < 40; t++) begin
      mode  = $urandom_range(0, 2);
      rd_en = (mode != 1);
      wr_en = (mode != 0);
      ra = $urandom;
      rl = $urandom_range(0, 15);
      sb = $urandom_range(0, rl);
      wa = ($urandom_range(0, 1) == 1) ? ra : $urandom;
      wl = $urandom_range(0, 15);
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, wl) : -1;
      for (int k = 0; k < 16; k++) wd_beats[k] = $urandom;
      run(rd_en, ra, rl, sb, $urandom_range(0, 3), wr_en, wa, wl,
          4'($urandom), eb, $urandom_range(0, 4));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_bus_mem_responder.md
# cache_bus_mem_responder

Memory-side responder for the cache/AXI interface bus. It is the target end of the simplified burst bus that the cache interface drives: `ren/raddr/rlen` reads and `wen/waddr/wdata/wlast/wlen` writes, with per-beat `rdata_valid` and `wdata_resp` returns. It holds a word-organised on-chip memory with configurable read and write latency. It is used as the bus end in SoC-level simulation and as a fast local RAM behind the cache interface.

## Interface
Parameters:
- `ADDR_W`, default 10: word-index width; memory is 2^ADDR_W 32-bit words. Index is `addr[ADDR_W+1:2]`, and upper address bits are ignored, so addresses wrap modulo the depth.
- `RD_LATENCY`, default 2: cycles from read acceptance to the first read beat. Legal values are 1 or more.
- `WR_LATENCY`, default 1: cycles from write acceptance to the first write response. Legal values are 1 or more.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ce_i` in 1: chip enable. While it is low, new reads and writes are not accepted.
- `ren_i` in 1: read request, held high by the initiator for the whole burst.
- `rready_i` in 1: initiator ready to take a read beat.
- `raddr_i` in 32: read address. It is captured at acceptance as the burst base.
- `rlen_i` in 4: read burst length minus 1. It is captured at acceptance.
- `rsel_i` in 4: read byte select. Ignored; the full word is always returned.
- `rdata_o` out 32: read beat data.
- `rdata_valid_o` out 1: read beat valid.
- `wen_i` in 1: write request, held high for the whole burst.
- `wvalid_i` in 1: write data valid.
- `waddr_i` in 32: address of the current write beat.
- `wdata_i` in 32: data of the current write beat.
- `wsel_i` in 4: byte enables. Bit i enables `wdata_i[8i+7:8i]`.
- `wlast_i` in 1: initiator's last-beat flag.
- `wlen_i` in 4: write burst length minus 1. It is captured at acceptance.
- `wdata_resp_o` out 1: one-cycle pulse per committed write beat.
- `proto_err_o` out 1: sticky protocol-error flag.

## Operation
- Read and write channels are independent FSMs and may run concurrently. The memory has one read port and one write port.

Read FSM, states `R_IDLE`, `R_WAIT`, `R_BURST`, `R_WAIT_LOW`:
- `R_IDLE`: when `ce_i & ren_i`, capture `base = raddr_i` word index and `len = rlen_i`, clear the beat counter `k`, and start the latency counter.
- `R_WAIT`: count down the latency.
- `R_BURST`: present beat k with `rdata_o = mem[(base+k) mod depth]`.
  - A beat completes in a cycle where `rdata_valid_o & rready_i`.
  - If `rready_i` is low, `rdata_valid_o` and `rdata_o` are held unchanged.
  - After beat `len` completes, go to `R_WAIT_LOW`.
- `R_WAIT_LOW`: stay until `ren_i == 0`, then go to `R_IDLE`. This prevents a still-high `ren_i` from re-triggering a burst.

Write FSM, states `W_IDLE`, `W_WAIT`, `W_RESP`, `W_WAIT_LOW`:
- `W_IDLE`: when `ce_i & wen_i & wvalid_i`, capture `len = wlen_i`, clear `k`, and start the latency counter.
- `W_RESP`: on each pulse, write `wdata_i` to `mem[waddr_i index]` under `wsel_i` at the end of that cycle. Address and data are taken from the live inputs, because the initiator advances its beat on `wdata_resp_o`.
  - After response `len`, go to `W_WAIT_LOW`, then to `W_IDLE` once `wen_i == 0`.
- Protocol check, in each `W_RESP` pulse cycle:
  - If `wvalid_i == 0`, or `wlast_i != (k == len)`, set `proto_err_o`. It is cleared only by `rst`.
  - The beat is still committed.

Reset and collisions:
- Memory contents are not reset.
- Collision: a read beat registered on the same edge as a write to the same word returns the OLD data (read-first).
- Reset asserted mid-burst: both FSMs go to IDLE immediately and all outputs go to 0. Memory keeps every beat already committed.

## Timing
- Reset values: `rdata_o = 0`, `rdata_valid_o = 0`, `wdata_resp_o = 0`, `proto_err_o = 0`. All outputs are registered.
- Read timing (cycle 0 = cycle in which `ren_i` is sampled high in `R_IDLE`):
  - Beat 0 is valid in cycle `RD_LATENCY`.
  - With `rready_i` held high, beats 0..len are valid in consecutive cycles `RD_LATENCY` through `RD_LATENCY+len`.
  - The earliest next acceptance is cycle `RD_LATENCY+len+2`.
- Write timing (cycle 0 = acceptance cycle):
  - Response k pulses in cycle `WR_LATENCY+k`, back to back.
  - The memory write for beat k occurs at the end of that same cycle.
- `len` range is 0–15. The beat counter is 4 bits and does not overflow within a burst.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → every output is 0 before the next edge; both FSMs are idle.
- **Write then read burst** (`WR_LATENCY=1`, `RD_LATENCY=2`):
  - Stimulus: 8-beat write at 0x100, data 0x10000000+k, `wsel=4'hF`, `wlast` correct.
  - Required: `wdata_resp_o` high in cycles 1–8 and `proto_err_o` stays 0.
  - Then an 8-beat read at 0x100 → `rdata_valid_o` high in cycles 2–9 with data 0x10000000..0x10000007.
- **Partial single-beat write:**
  - Stimulus: `wlen=0`, 0x104, data 0xAAAABBBB, `wsel=4'b0011`.
  - Required: the word becomes 0x1000BBBB; a 1-beat read (`rlen=0`) returns 0x1000BBBB.
- **Collision:**
  - Stimulus: a read beat of 0x108 on the same edge as a write of 0xDEADBEEF to 0x108.
  - Required: the read returns the old 0x10000002; a later read returns 0xDEADBEEF.
- **Read stall:** drop `rready_i` for 2 cycles during beat 3 → `rdata_valid_o` and `rdata_o` are held steady, no beat is skipped or duplicated, and the last beat is delayed by 2 cycles.
- **Protocol error and reset mid-burst:**
  - Stimulus: `wlast_i` high on beat 2 of an 8-beat write.
  - Required: `proto_err_o` goes 1 and stays set; all 8 beats are still committed.
  - Then assert reset during a read burst → `rdata_valid_o` goes 0 immediately, `proto_err_o` clears, and memory retains the written data.
